// File: rtl/f11_vic_if.sv
// F-11 interrupt / fast-input Wishbone port.
// The CPU side drives the strobe and the fast-input qualifier.
// The controller side returns the data word and the acknowledge.
interface f11_vic_if;
  logic        wbi_stb_i;
  logic        wbi_una_i;
  logic [15:0] wbi_dat_o;
  logic        wbi_ack_o;

  modport master (
    output wbi_stb_i,
    output wbi_una_i,
    input  wbi_dat_o,
    input  wbi_ack_o
  );

  modport slave (
    input  wbi_stb_i,
    input  wbi_una_i,
    output wbi_dat_o,
    output wbi_ack_o
  );
endinterface

// File: rtl/f11_vic.sv
// f11_vic: vectored interrupt controller for the F-11 Wishbone system.
//
// Behaviour:
// - Folds device requests onto the four CPU priority lines vm_virq[7:4].
// - Answers interrupt-acknowledge strobes with the winning source's vector.
// - Answers fast-input reads with the board configuration word.
// - Pulses irq_ack back to the winning device.
//
// Optional macro F11_VIC_SPURIOUS_EN:
// - Defined: an acknowledge with nothing pending is answered with DEF_VEC.
// - Undefined: it is left unanswered, so the CPU bus timer aborts the cycle.
//
// The bus outputs are registers loaded on the transition into ACK, FDIN or
// NOREQ. The output registers therefore double as the latched winner
// (vector and index), and wbi_dat_o naturally holds its value in DONE.
module f11_vic #(
  parameter int              NIRQ    = 8,
  parameter logic [2*NIRQ-1:0] LVL   = {NIRQ{2'b11}},
  parameter logic [8:0]      DEF_VEC = 9'o000
) (
  input  logic              vm_clk_p,
  input  logic              vm_init_n,
  input  logic [NIRQ-1:0]   irq_req,
  input  logic [7*NIRQ-1:0] irq_vec,
  output logic [NIRQ-1:0]   irq_ack,
  output logic [7:4]        vm_virq,
  input  logic [15:0]       fdin_dat,
  f11_vic_if.slave          wbi
);

  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ACK,
    FDIN,
    DONE,
    NOREQ
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      virq_nx;
  logic            found;
  logic [IW-1:0]   win;
  logic            ack_q;
  logic            ack_nx;
  logic [15:0]     dat_q;
  logic [15:0]     dat_nx;
  logic [NIRQ-1:0] irq_ack_q;
  logic [NIRQ-1:0] irq_ack_nx;

  // OR each request into the priority line selected by its level field
  always_comb begin
    virq_nx = '0;
    for (int i = 0; i < NIRQ; i++) begin
      virq_nx[LVL[2*i +: 2]] = virq_nx[LVL[2*i +: 2]] | irq_req[i];
    end
  end

  // Pick the highest-level pending source, lowest index first within a level
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int lv = 3; lv >= 0; lv--) begin
      for (int i = 0; i < NIRQ; i++) begin
        if (!found && irq_req[i] && (LVL[2*i +: 2] == 2'(lv))) begin
          found = 1'b1;
          win   = IW'(i);
        end
      end
    end
  end

  // State register
  always_ff @(posedge vm_clk_p) begin
    if (!vm_init_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and the values the bus outputs take in the next state
  always_comb begin
    state_nx   = state;
    ack_nx     = 1'b0;
    dat_nx     = dat_q;
    irq_ack_nx = '0;
    case (state)
      IDLE: begin
        if (wbi.wbi_stb_i) begin
          if (wbi.wbi_una_i) begin
            state_nx = FDIN;
            ack_nx   = 1'b1;
            dat_nx   = fdin_dat;
          end else begin
            state_nx = ARB;
          end
        end
      end
      ARB: begin
        if (found) begin
          state_nx   = ACK;
          ack_nx     = 1'b1;
          dat_nx     = {7'b0, irq_vec[7*int'(win) +: 7], 2'b00};
          irq_ack_nx = NIRQ'(1) << win;
        end else begin
          state_nx = NOREQ;
`ifdef F11_VIC_SPURIOUS_EN
          ack_nx   = 1'b1;
          dat_nx   = {7'b0, DEF_VEC};
`endif
        end
      end
      ACK, FDIN: begin
        state_nx = DONE;
      end
      DONE: begin
        if (!wbi.wbi_stb_i) begin
          state_nx = IDLE;
        end
      end
      NOREQ: begin
`ifdef F11_VIC_SPURIOUS_EN
        state_nx = DONE;
`else
        if (!wbi.wbi_stb_i) begin
          state_nx = IDLE;
        end
`endif
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Registered bus outputs, acknowledge pulse and priority lines
  always_ff @(posedge vm_clk_p) begin
    if (!vm_init_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_ack_q <= '0;
      vm_virq   <= '0;
    end else begin
      ack_q     <= ack_nx;
      dat_q     <= dat_nx;
      irq_ack_q <= irq_ack_nx;
      vm_virq   <= virq_nx;
    end
  end

  assign wbi.wbi_ack_o = ack_q;
  assign wbi.wbi_dat_o = dat_q;
  assign irq_ack       = irq_ack_q;

endmodule
